hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: two-entry write scoreboard for RAW stalls,
// EX redirect flushing, and a halt sequencer that drains the pipe before halting.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_rs1,
  input  logic [2:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        id_regwrite,
  input  logic [2:0]  id_wreg,
  input  logic        id_halt,
  input  logic        ex_redirect,
  output logic        stall,
  output logic        nop,
  output logic        flush_ifid,
  output logic        halted,
  output logic [1:0]  hz_state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_e;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  drain_cnt_q, drain_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        s0_v_q, s0_v_d;
  logic [2:0]  s0_r_q, s0_r_d;
  logic        s1_v_q, s1_v_d;
  logic [2:0]  s1_r_q, s1_r_d;

  logic match_rs1;
  logic match_rs2;
  logic hazard;
  logic issue;

  // Only ID/EX and EX/MEM writers are checked; MEM/WB is covered by the
  // register file writing before it is read.
  always_comb begin
    match_rs1 = (s0_v_q && (s0_r_q == id_rs1)) || (s1_v_q && (s1_r_q == id_rs1));
    match_rs2 = (s0_v_q && (s0_r_q == id_rs2)) || (s1_v_q && (s1_r_q == id_rs2));
    hazard    = id_valid && ((id_rs1_used && match_rs1) || (id_rs2_used && match_rs2));
  end

  always_comb begin
    stall       = 1'b0;
    nop         = 1'b0;
    flush_ifid  = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          nop        = 1'b1;
          flush_ifid = 1'b1;
        end else if (hazard) begin
          stall = 1'b1;
          nop   = 1'b1;
          if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end else if (id_valid && id_halt) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        stall       = 1'b1;
        nop         = 1'b1;
        drain_cnt_d = drain_cnt_q - 3'd1;
        if (drain_cnt_q == 3'd1) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        stall  = 1'b1;
        nop    = 1'b1;
        halted = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    issue  = id_valid && !nop;
    s1_v_d = s0_v_q;
    s1_r_d = s0_r_q;
    s0_v_d = issue ? id_regwrite : 1'b0;
    s0_r_d = issue ? id_wreg : 3'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      drain_cnt_q <= 3'd0;
      stall_cnt_q <= 16'd0;
      s0_v_q      <= 1'b0;
      s0_r_q      <= 3'd0;
      s1_v_q      <= 1'b0;
      s1_r_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      s0_v_q      <= s0_v_d;
      s0_r_q      <= s0_r_d;
      s1_v_q      <= s1_v_d;
      s1_r_q      <= s1_r_d;
    end
  end

  assign hz_state  = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for stall/flush behaviour,
// then hand sequences for halt draining, async reset and counter saturation.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic        id_regwrite;
  logic [2:0]  id_wreg;
  logic        id_halt;
  logic        ex_redirect;
  logic        stall;
  logic        nop;
  logic        flush_ifid;
  logic        halted;
  logic [1:0]  hz_state;
  logic [15:0] stall_cnt;

  int checks;
  int errors;

  typedef struct {
    logic       valid;
    logic [2:0] rs1;
    logic       rs1_used;
    logic [2:0] rs2;
    logic       rs2_used;
    logic       regwrite;
    logic [2:0] wreg;
    logic       halt;
    logic       redirect;
    logic [3:0] exp_flags;
    logic [1:0] exp_state;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[21];

  hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_regwrite (id_regwrite),
    .id_wreg     (id_wreg),
    .id_halt     (id_halt),
    .ex_redirect (ex_redirect),
    .stall       (stall),
    .nop         (nop),
    .flush_ifid  (flush_ifid),
    .halted      (halted),
    .hz_state    (hz_state),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [2:0] r1, input logic u1,
                              input logic [2:0] r2, input logic u2, input logic rw,
                              input logic [2:0] wr, input logic h, input logic rd,
                              input logic [3:0] fl, input logic [1:0] st,
                              input logic [15:0] cnt);
    vec_t t;
    t.valid = v;   t.rs1 = r1; t.rs1_used = u1; t.rs2 = r2; t.rs2_used = u2;
    t.regwrite = rw; t.wreg = wr; t.halt = h; t.redirect = rd;
    t.exp_flags = fl; t.exp_state = st; t.exp_cnt = cnt;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    id_valid    = t.valid;
    id_rs1      = t.rs1;
    id_rs1_used = t.rs1_used;
    id_rs2      = t.rs2;
    id_rs2_used = t.rs2_used;
    id_regwrite = t.regwrite;
    id_wreg     = t.wreg;
    id_halt     = t.halt;
    ex_redirect = t.redirect;
  endtask

  task automatic checkAll(input string tag, input logic [3:0] fl, input logic [1:0] st,
                          input logic [15:0] cnt);
    checkOutput({tag, " flags"}, {12'd0, stall, nop, flush_ifid, halted}, {12'd0, fl});
    checkOutput({tag, " hz_state"}, {14'd0, hz_state}, {14'd0, st});
    checkOutput({tag, " stall_cnt"}, stall_cnt, cnt);
  endtask

  // One clock cycle: drive at posedge+1, check combinational outputs mid-cycle.
  task automatic runVector(input string tag, input vec_t t);
    applyStimulus(t);
    #3;
    checkAll(tag, t.exp_flags, t.exp_state, t.exp_cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 16'd0));
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Sequence from reset; flags are {stall, nop, flush_ifid, halted}.
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 16'd0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 4'b0000, 2'b00, 16'd0);
    vecs[2]  = mk(1, 3, 1, 0, 0, 1, 4, 0, 0, 4'b1100, 2'b00, 16'd0);
    vecs[3]  = mk(1, 3, 1, 0, 0, 1, 4, 0, 0, 4'b1100, 2'b00, 16'd1);
    vecs[4]  = mk(1, 3, 1, 0, 0, 1, 4, 0, 0, 4'b0000, 2'b00, 16'd2);
    vecs[5]  = mk(1, 4, 0, 0, 0, 1, 5, 0, 0, 4'b0000, 2'b00, 16'd2);
    vecs[6]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 16'd2);
    vecs[7]  = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 4'b1100, 2'b00, 16'd2);
    vecs[8]  = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 4'b0000, 2'b00, 16'd3);
    vecs[9]  = mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 4'b0000, 2'b00, 16'd3);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 16'd3);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 16'd3);
    vecs[12] = mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 16'd3);
    vecs[13] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 4'b0000, 2'b00, 16'd3);
    vecs[14] = mk(1, 2, 1, 0, 0, 0, 0, 0, 1, 4'b0110, 2'b00, 16'd3);
    vecs[15] = mk(1, 0, 0, 2, 1, 0, 0, 0, 0, 4'b1100, 2'b00, 16'd3);
    vecs[16] = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 4'b0000, 2'b00, 16'd4);
    vecs[17] = mk(0, 7, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 16'd4);
    vecs[18] = mk(1, 7, 1, 0, 0, 0, 0, 1, 1, 4'b0110, 2'b00, 16'd4);
    vecs[19] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0110, 2'b00, 16'd4);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 16'd4);

    rst = 1'b0;
    setIdle();
    #2;
    checkAll("reset", 4'b0000, 2'b00, 16'd0);
    @(posedge clk);
    #1;
    checkAll("reset held", 4'b0000, 2'b00, 16'd0);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Halt behind a RAW hazard: it waits out the stall, then issues and drains.
    runVector("halt w", mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 2'b00, 16'd4));
    runVector("halt s1", mk(1, 1, 1, 0, 0, 1, 1, 1, 0, 4'b1100, 2'b00, 16'd4));
    runVector("halt s2", mk(1, 1, 1, 0, 0, 1, 1, 1, 0, 4'b1100, 2'b00, 16'd5));
    runVector("halt t", mk(1, 1, 1, 0, 0, 1, 1, 1, 0, 4'b0000, 2'b00, 16'd6));
    for (int k = 1; k <= 3; k++) begin
      runVector($sformatf("drain t+%0d", k),
                mk(1, 1, 1, 0, 0, 1, 1, 1, 1, 4'b1100, 2'b01, 16'd6));
    end
    for (int k = 4; k <= 6; k++) begin
      runVector($sformatf("halted t+%0d", k),
                mk(1, 1, 1, 0, 0, 1, 1, 1, 1, 4'b1101, 2'b10, 16'd6));
    end

    // Asynchronous reset out of HALTED, no clock edge involved.
    setIdle();
    #2;
    rst = 1'b0;
    #1;
    checkAll("rst halted", 4'b0000, 2'b00, 16'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Second halt, then reset asserted between edges while draining.
    runVector("halt2 t", mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 2'b00, 16'd0));
    runVector("halt2 t+1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 2'b01, 16'd0));
    setIdle();
    #2;
    checkAll("halt2 t+2", 4'b1100, 2'b01, 16'd0);
    rst = 1'b0;
    #1;
    checkAll("rst drain", 4'b0000, 2'b00, 16'd0);
    @(posedge clk);
    #1;
    checkAll("rst drain held", 4'b0000, 2'b00, 16'd0);
    rst = 1'b1;

    // Self-dependent instruction held in ID: issue, stall, stall, repeating.
    applyStimulus(mk(1, 1, 1, 0, 0, 1, 1, 0, 0, 4'b0000, 2'b00, 16'd0));
    repeat (3 * 32767) @(posedge clk);
    #1;
    checkOutput("sat pre", stall_cnt, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sat reach", stall_cnt, 16'hFFFF);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("sat hold", stall_cnt, 16'hFFFF);
    checkOutput("sat state", {14'd0, hz_state}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
